wb_result_pipe: RTL and testbench
=================================

// Module: wb_result_pipe
// PURPOSE
//  Parametrised writeback-stage result selector with output pipeline register.
//  Picks one of NSRC result sources (ALU, load data, PC+4, immediate, ...) and registers it with the dest reg and write enable.
//  Uses a valid/ready handshake so the WB stage can stall.
//  Sits between MEM/WB and the register file write port; its registered output also drives the forwarding unit.
// PARAMETERS
//  WIDTH   32  data width of each source and of the result
//  NSRC    4   number of result sources (>=2); 0=ALU, 1=load data, 2=PC+4, 3=imm
//  REG_AW  5   register-file address width
// PORTS
//  clk          in   1            clock, rising edge
//  rst_n        in   1            asynchronous active-low reset
//  in_valid     in   1            upstream result valid
//  in_ready     out  1            block can accept a result this cycle
//  src_data     in   NSRC*WIDTH   flattened sources, src k at [k*WIDTH +: WIDTH]
//  sel          in   $clog2(NSRC) source select
//  rd_in        in   REG_AW       destination register
//  we_in        in   1            instruction writes a register
//  ld_funct3    in   3            load type (RISC-V funct3), used for source 1
//  ld_off       in   2            load byte offset (addr[1:0])
//  flush        in   1            discard the held result
//  out_valid    out  1            registered result valid
//  out_ready    in   1            downstream (regfile / hazard unit) accepts
//  result       out  WIDTH        registered selected result
//  rd_out       out  REG_AW       registered destination
//  we_out       out  1            registered write enable, gated as below
//  sel_err      out  1            sticky: out-of-range sel captured
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, result=0, rd_out=0, we_out=0, sel_err=0.
//  in_ready = !out_valid || out_ready (combinational; one-entry pipe, full throughput).
//  capture = in_valid && in_ready; on capture, next edge loads result/rd_out/we_out and sets out_valid=1.
//  Latency: exactly 1 cycle from capture to out_valid.
//  out_valid && out_ready && !capture -> out_valid=0 next edge; data regs keep their values.
//  While out_valid && !out_ready, result/rd_out/we_out are held stable.
//  flush: highest priority; next edge out_valid=0 and the same-cycle capture is dropped.
//  Selection: sel<NSRC -> src sel; sel>=NSRC -> result 0, we 0, sel_err set (sticky until reset).
//  we_out = we_in && (rd_in != 0) at capture; writes to x0 never leave the block.
//  All arithmetic is width-exact; no truncation except load extension below.
//  Reset mid-stall: result dropped immediately, in_ready=1 after reset release.
// CONFIGURATION
//  Macro WB_LOAD_EXT_EN.
//  Defined: source 1 is shifted right by ld_off*8, then extended per ld_funct3.
//    000 LB sign-ext byte; 001 LH sign-ext half; 010 LW raw.
//    100 LBU zero-ext byte; 101 LHU zero-ext half; other codes raw.
//  Not defined: source 1 passes raw. ld_funct3 and ld_off remain ports but are ignored.
// STRUCTURE
//  Package wb_pkg: WB_SRC_ALU/LOAD/PC4/IMM index constants and the LD_* funct3 constants.
//  Sub-module load_ext (combinational, WIDTH-param); instantiated only under WB_LOAD_EXT_EN.
//  Top holds the mux, handshake and pipeline register.
// TESTING
//  1 Reset: rst_n=0 at any cycle -> out_valid=0, result=0, sel_err=0 within the same cycle.
//  2 Select: src0=0x11, src2=0x1004, sel=2, rd=5, we=1, out_ready=1
//    -> next cycle out_valid=1, result=0x1004, rd_out=5, we_out=1.
//  3 Stall: out_ready=0 with out_valid=1 -> in_ready=0, output held 3 cycles.
//    out_ready=1 with a new in_valid -> back-to-back transfer, no bubble.
//  4 x0 / error: rd=0, we=1 -> we_out=0.
//    NSRC=3, sel=3 -> result=0, we_out=0, sel_err=1 and stays 1 after later valid ops.
//  5 Load ext (macro on): src1=0x80FF7F01, sel=1.
//    LB off=3 -> 0xFFFFFF80; LBU off=1 -> 0x0000007F; LH off=2 -> 0xFFFF80FF.
//    Macro off -> 0x80FF7F01.
//  6 Flush: flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0, nothing captured.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the writeback result pipe: source indices and load funct3 codes.
package wb_pkg;

  localparam int WB_SRC_ALU  = 0;
  localparam int WB_SRC_LOAD = 1;
  localparam int WB_SRC_PC4  = 2;
  localparam int WB_SRC_IMM  = 3;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_funct3_e;

endpackage

// File: rtl/wb_load_ext.sv
// Load data aligner/extender (combinational). Only elaborated when WB_LOAD_EXT_EN is defined;
// in the default build this file contributes no module.
`ifdef WB_LOAD_EXT_EN
module load_ext
  import wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] raw_i,
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       off_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] shifted;

  // Byte offset moves the addressed byte/half down to bit 0 before extension.
  assign shifted = raw_i >> {off_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (funct3_i)
      LD_LB:   data_o = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      LD_LH:   data_o = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      LD_LBU:  data_o = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      LD_LHU:  data_o = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule
`endif

// File: rtl/wb_result_pipe.sv
// Writeback result selector with a one-entry valid/ready output register.
// Define WB_LOAD_EXT_EN to align and sign/zero-extend the load source (index 1).
module wb_result_pipe
  import wb_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NSRC   = 4,
  parameter  int REG_AW = 5,
  localparam int SEL_W  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic [REG_AW-1:0]     rd_in,
  input  logic                  we_in,
  input  logic [2:0]            ld_funct3,
  input  logic [1:0]            ld_off,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic [REG_AW-1:0]     rd_out,
  output logic                  we_out,
  output logic                  sel_err
);

  logic [WIDTH-1:0] src_arr [NSRC];

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      if (gi == WB_SRC_LOAD) begin : g_load
`ifdef WB_LOAD_EXT_EN
        load_ext #(.WIDTH(WIDTH)) u_load_ext (
          .raw_i    (src_data[gi*WIDTH +: WIDTH]),
          .funct3_i (ld_funct3),
          .off_i    (ld_off),
          .data_o   (src_arr[gi])
        );
`else
        assign src_arr[gi] = src_data[gi*WIDTH +: WIDTH];
`endif
      end else begin : g_raw
        assign src_arr[gi] = src_data[gi*WIDTH +: WIDTH];
      end
    end
  endgenerate

`ifndef WB_LOAD_EXT_EN
  logic unused_ld;
  assign unused_ld = ^{ld_funct3, ld_off};
`endif

  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;

  // An out-of-range select matches nothing and yields zero data.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = src_arr[k];
        sel_hit  = 1'b1;
      end
    end
  end

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              we_q, we_d;
  logic              sel_err_q, sel_err_d;
  logic              capture;

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    rd_d        = rd_q;
    we_d        = we_q;
    sel_err_d   = sel_err_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      result_d    = sel_data;
      rd_d        = rd_in;
      // x0 writes and bad selects are squashed here so the regfile never sees them.
      we_d        = we_in && (rd_in != '0) && sel_hit;
      sel_err_d   = sel_err_q || !sel_hit;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign rd_out    = rd_q;
  assign we_out    = we_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_wb_result_pipe.sv
// Randomized bench for wb_result_pipe: a 4-source and a 3-source instance share stimulus
// and are checked against a transaction-level reference model.
module tb_wb_result_pipe;
  import wb_pkg::*;

  localparam int W  = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, out_ready, flush, we_in;
  logic [1:0]    sel;
  logic [AW-1:0] rd_in;
  logic [2:0]    ld_funct3;
  logic [1:0]    ld_off;
  logic [W-1:0]  src [4];

  logic [4*W-1:0] src_flat4;
  logic [3*W-1:0] src_flat3;
  assign src_flat4 = {src[3], src[2], src[1], src[0]};
  assign src_flat3 = {src[2], src[1], src[0]};

  logic          in_ready_o  [2];
  logic          out_valid_o [2];
  logic [W-1:0]  res_o       [2];
  logic [AW-1:0] rd_o        [2];
  logic          we_o        [2];
  logic          err_o       [2];

  wb_result_pipe #(.WIDTH(W), .NSRC(4), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .src_data(src_flat4), .sel(sel), .rd_in(rd_in), .we_in(we_in),
    .ld_funct3(ld_funct3), .ld_off(ld_off), .flush(flush),
    .out_valid(out_valid_o[0]), .out_ready(out_ready), .result(res_o[0]),
    .rd_out(rd_o[0]), .we_out(we_o[0]), .sel_err(err_o[0])
  );

  wb_result_pipe #(.WIDTH(W), .NSRC(3), .REG_AW(AW)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .src_data(src_flat3), .sel(sel), .rd_in(rd_in), .we_in(we_in),
    .ld_funct3(ld_funct3), .ld_off(ld_off), .flush(flush),
    .out_valid(out_valid_o[1]), .out_ready(out_ready), .result(res_o[1]),
    .rd_out(rd_o[1]), .we_out(we_o[1]), .sel_err(err_o[1])
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state per instance (0: NSRC=4, 1: NSRC=3).
  bit            m_valid [2];
  logic [W-1:0]  m_res   [2];
  logic [AW-1:0] m_rd    [2];
  bit            m_we    [2];
  bit            m_err   [2];

  function automatic logic [W-1:0] ld_model(input logic [W-1:0] raw, input logic [2:0] f3,
                                            input logic [1:0] off);
`ifdef WB_LOAD_EXT_EN
    logic [W-1:0] v;
    logic [W-1:0] b;
    logic [W-1:0] h;
    v = raw / (32'd1 << (int'(off) * 8));
    b = v % 32'd256;
    h = v % 32'd65536;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return v;
    endcase
`else
    return raw + 32'd0 + {29'd0, f3} * 32'd0 + {30'd0, off} * 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_res[d] = '0; m_rd[d] = '0; m_we[d] = 0; m_err[d] = 0;
    end
  endtask

  task automatic model_update();
    int nsrc;
    bit acc;
    for (int d = 0; d < 2; d++) begin
      nsrc = (d == 0) ? 4 : 3;
      acc  = in_valid && (!m_valid[d] || out_ready) && !flush;
      if (flush) begin
        m_valid[d] = 0;
      end else if (acc) begin
        m_valid[d] = 1;
        m_rd[d]    = rd_in;
        if (int'(sel) < nsrc) begin
          m_res[d] = (int'(sel) == WB_SRC_LOAD) ? ld_model(src[1], ld_funct3, ld_off) : src[sel];
          m_we[d]  = we_in && (rd_in != 0);
        end else begin
          m_res[d] = '0;
          m_we[d]  = 0;
          m_err[d] = 1;
        end
        if (d == 0)
          $display("txn t=%0t sel=%0d rd=%0d we=%0b -> result=0x%08h we_out=%0b",
                   $time, sel, rd_in, we_in, m_res[0], m_we[0]);
      end else if (m_valid[d] && out_ready) begin
        m_valid[d] = 0;
      end
    end
  endtask

  task automatic check_outs(input string pfx);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_u%0d_out_valid", pfx, d), {31'd0, out_valid_o[d]}, {31'd0, m_valid[d]});
      chk($sformatf("%s_u%0d_result", pfx, d), res_o[d], m_res[d]);
      chk($sformatf("%s_u%0d_rd_out", pfx, d), {27'd0, rd_o[d]}, {27'd0, m_rd[d]});
      chk($sformatf("%s_u%0d_we_out", pfx, d), {31'd0, we_o[d]}, {31'd0, m_we[d]});
      chk($sformatf("%s_u%0d_sel_err", pfx, d), {31'd0, err_o[d]}, {31'd0, m_err[d]});
    end
  endtask

  // Inputs are already driven (just after a negedge); one full cycle is applied and checked.
  task automatic tick(input string pfx);
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s_u%0d_in_ready", pfx, d), {31'd0, in_ready_o[d]},
          {31'd0, (!m_valid[d] || out_ready)});
    model_update();
    @(posedge clk);
    #1;
    check_outs(pfx);
    @(negedge clk);
  endtask

  task automatic drive(input string pfx, input bit v, input logic [1:0] s, input logic [AW-1:0] rd,
                       input bit we, input bit ordy, input bit fl);
    in_valid  = v;
    sel       = s;
    rd_in     = rd;
    we_in     = we;
    out_ready = ordy;
    flush     = fl;
    tick(pfx);
  endtask

  initial begin
    in_valid = 0; out_ready = 0; flush = 0; we_in = 0; sel = '0; rd_in = '0;
    ld_funct3 = 3'b010; ld_off = 2'd0;
    for (int k = 0; k < 4; k++) src[k] = '0;
    model_reset();

    #2;
    check_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic select
    src[0] = 32'h11; src[2] = 32'h1004; src[3] = 32'hCAFE0003;
    drive("sel", 1, 2'd2, 5'd5, 1, 1, 0);
    chk("sel_result_const", res_o[0], 32'h1004);
    chk("sel_rd_const", {27'd0, rd_o[0]}, 32'd5);

    // Stall: output must hold while new data is offered
    for (int i = 0; i < 3; i++) begin
      src[0] = $urandom;
      drive("stall", 1, 2'd0, 5'd7, 1, 0, 0);
    end
    chk("stall_hold_const", res_o[0], 32'h1004);
    src[0] = 32'h0000BEEF;
    drive("b2b0", 1, 2'd0, 5'd8, 1, 1, 0);
    drive("b2b1", 1, 2'd3, 5'd9, 1, 1, 0);
    chk("b2b_valid_const", {31'd0, out_valid_o[0]}, 32'd1);
    chk("b2b_result_const", res_o[0], 32'hCAFE0003);

    // x0 write and out-of-range select on the 3-source instance
    drive("x0", 1, 2'd2, 5'd0, 1, 1, 0);
    chk("x0_we_const", {31'd0, we_o[0]}, 32'd0);
    drive("selerr", 1, 2'd3, 5'd4, 1, 1, 0);
    chk("selerr_res_const", res_o[1], 32'd0);
    chk("selerr_flag_const", {31'd0, err_o[1]}, 32'd1);
    drive("sticky", 1, 2'd0, 5'd6, 1, 1, 0);
    chk("sticky_flag_const", {31'd0, err_o[1]}, 32'd1);

    // Load source
    src[1] = 32'h80FF7F01;
`ifdef WB_LOAD_EXT_EN
    ld_funct3 = 3'b000; ld_off = 2'd3;
    drive("lb", 1, 2'd1, 5'd3, 1, 1, 0);
    chk("lb_const", res_o[0], 32'hFFFFFF80);
    ld_funct3 = 3'b100; ld_off = 2'd1;
    drive("lbu", 1, 2'd1, 5'd3, 1, 1, 0);
    chk("lbu_const", res_o[0], 32'h0000007F);
    ld_funct3 = 3'b001; ld_off = 2'd2;
    drive("lh", 1, 2'd1, 5'd3, 1, 1, 0);
    chk("lh_const", res_o[0], 32'hFFFF80FF);
`else
    ld_funct3 = 3'b000; ld_off = 2'd3;
    drive("ldraw", 1, 2'd1, 5'd3, 1, 1, 0);
    chk("ldraw_const", res_o[0], 32'h80FF7F01);
`endif

    // Flush with a held result and a simultaneous offer
    drive("preflush", 1, 2'd0, 5'd10, 1, 0, 0);
    drive("flush", 1, 2'd2, 5'd11, 1, 1, 1);
    chk("flush_valid_const", {31'd0, out_valid_o[0]}, 32'd0);

    // Async reset during a stall
    drive("rs0", 1, 2'd2, 5'd12, 1, 0, 0);
    drive("rs1", 1, 2'd0, 5'd13, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", {31'd0, in_ready_o[0]}, 32'd1);
    in_valid = 0; flush = 0;
    tick("postrst");

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < 4; k++) src[k] = $urandom;
      ld_funct3 = 3'($urandom_range(0, 7));
      ld_off    = 2'($urandom_range(0, 3));
      drive("rnd", ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom_range(0, 1) == 1, ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
